// File: rtl/pipe_datapath.sv
// -----------------------------------------------------------------------------
// pipe_datapath
// Two-stage integer datapath: register file + ALU (EX, combinational from the
// request) feeding a registered OUT stage with a valid/ready handshake on both
// sides. Results retire into the register file when the consumer takes them,
// and the in-flight OUT result is forwarded to a dependent request in EX.
//
// Ports
//   clk        rising-edge clock for all state
//   reset      synchronous, active-low reset
//   in_valid   request valid
//   in_ready   block can accept a request this cycle (combinational)
//   rs1_addr   source register A index
//   rs2_addr   source register B index
//   rd_addr    destination register index
//   alu_ctrl   4-bit operation select
//   wr_en      write result back to rd_addr on retirement
//   out_valid  result/zero_flag hold an unretired operation
//   out_ready  consumer accepts the result
//   result     registered ALU result
//   zero_flag  registered (result == 0)
//   dbg_addr   debug read index
//   dbg_data   committed register contents at dbg_addr (combinational)
// -----------------------------------------------------------------------------
module pipe_datapath #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rd_addr,
    input  logic [3:0]      alu_ctrl,
    input  logic            wr_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero_flag,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    // Architectural register file; entry 0 is never written.
    logic [XLEN-1:0] regs [NREGS];

    // OUT stage bookkeeping (result/zero_flag/out_valid are the ports).
    logic [AW-1:0]   out_rd;
    logic            out_wr_en;

    logic            accept;
    logic            retire;
    logic            fwd_a;
    logic            fwd_b;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;

    // Handshake: OUT can take a new operation if empty or draining this cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign retire   = out_valid && out_ready;

    // Forward the pending OUT result when it will be written to a source reg.
    assign fwd_a = out_valid && out_wr_en && (out_rd != '0) && (rs1_addr == out_rd);
    assign fwd_b = out_valid && out_wr_en && (out_rd != '0) && (rs2_addr == out_rd);

    // Operand select: x0 is hard zero, then forwarding, then committed state.
    always_comb begin
        op_a = regs[rs1_addr];
        op_b = regs[rs2_addr];
        if (fwd_a) begin
            op_a = result;
        end
        if (fwd_b) begin
            op_b = result;
        end
        if (rs1_addr == '0) begin
            op_a = '0;
        end
        if (rs2_addr == '0) begin
            op_b = '0;
        end
    end

    assign shamt = op_b[SHW-1:0];

    // ALU; unlisted codes yield zero.
    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> shamt);
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            ALU_NOR:  alu_res = ~(op_a | op_b);
            default:  alu_res = '0;
        endcase
    end

    // OUT stage: load on accept, clear on retire-only, hold otherwise.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero_flag <= 1'b0;
            out_rd    <= '0;
            out_wr_en <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            zero_flag <= (alu_res == '0);
            out_rd    <= rd_addr;
            out_wr_en <= wr_en;
        end else if (retire) begin
            out_valid <= 1'b0;
        end
    end

    // Writeback on retirement; reset wins and drops any pending write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (retire && out_wr_en && (out_rd != '0)) begin
            regs[out_rd] <= result;
        end
    end

    // Debug port sees committed state only.
    assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: tb/tb_pipe_datapath.sv
// -----------------------------------------------------------------------------
// tb_pipe_datapath
// Self-checking bench: directed vector tables, hand sequences for handshake
// and reset corners, randomized traffic against a sequential-semantics model,
// and a short run on a 16-bit / 8-register instance.
// -----------------------------------------------------------------------------
module tb_pipe_datapath;

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SRL  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_SLT  = 4'h7;
    localparam logic [3:0] OP_SRA  = 4'h8;
    localparam logic [3:0] OP_SLTU = 4'h9;
    localparam logic [3:0] OP_NOR  = 4'hC;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  d;
        logic        we;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 32-bit / 32-register instance
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [3:0]  alu_ctrl;
    logic        wr_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero_flag;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    pipe_datapath #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .alu_ctrl(alu_ctrl), .wr_en(wr_en), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero_flag(zero_flag),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // 16-bit / 8-register instance
    logic        s_in_valid;
    logic        s_in_ready;
    logic [2:0]  s_rs1;
    logic [2:0]  s_rs2;
    logic [2:0]  s_rd;
    logic [3:0]  s_alu;
    logic        s_wr_en;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_result;
    logic        s_zero_flag;
    logic [2:0]  s_dbg_addr;
    logic [15:0] s_dbg_data;

    pipe_datapath #(.XLEN(16), .NREGS(8)) dut16 (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .rs1_addr(s_rs1), .rs2_addr(s_rs2), .rd_addr(s_rd),
        .alu_ctrl(s_alu), .wr_en(s_wr_en), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .result(s_result), .zero_flag(s_zero_flag),
        .dbg_addr(s_dbg_addr), .dbg_data(s_dbg_data)
    );

    int checks = 0;
    int fails  = 0;

    // Model: mspec is the register view in program order (every accepted op
    // already applied), mcom is what has actually retired.
    logic [31:0] mspec [32];
    logic [31:0] mcom  [32];
    logic        m_valid;
    logic [31:0] m_res;
    logic        m_zf;
    logic [4:0]  m_rd;
    logic        m_we;
    logic        held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        int unsigned sh;
        sh = b % 32;
        r  = 32'd0;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SUB:  r = a - b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SRA: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_NOR:  r = ~(a | b);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Advance the model by one clock edge using the inputs present before it.
    task automatic model_update();
        logic acc;
        logic ret;
        logic [31:0] r;
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                mspec[i] = 32'd0;
                mcom[i]  = 32'd0;
            end
            m_valid = 1'b0; m_res = 32'd0; m_zf = 1'b0; m_rd = 5'd0; m_we = 1'b0;
            held = 1'b0;
        end else begin
            acc = in_valid && (!m_valid || out_ready);
            ret = m_valid && out_ready;
            if (ret && m_we && m_rd != 5'd0) mcom[m_rd] = m_res;
            if (acc) begin
                r = ref_alu(alu_ctrl, mspec[rs1_addr], mspec[rs2_addr]);
                m_res = r; m_zf = (r == 32'd0); m_rd = rd_addr; m_we = wr_en;
                m_valid = 1'b1;
                if (wr_en && rd_addr != 5'd0) mspec[rd_addr] = r;
            end else if (ret) begin
                m_valid = 1'b0;
            end
            held = in_valid && !acc;
        end
    endtask

    task automatic compare_all();
        chk("in_ready",  32'(in_ready),  32'(!m_valid || out_ready));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("result",    result,         m_res);
        chk("zero_flag", 32'(zero_flag), 32'(m_zf));
        chk("dbg_data",  dbg_data,       mcom[dbg_addr]);
    endtask

    // Called at posedge+1; checks mid-cycle, then crosses one edge.
    task automatic step();
        #3;
        compare_all();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic we);
        alu_ctrl = op; rs1_addr = a; rs2_addr = b; rd_addr = d; wr_en = we;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // x31 = 1, used as the increment when building constants.
    task automatic make_one();
        issue(OP_NOR, 5'd0, 5'd0, 5'd31, 1'b1);
        issue(OP_SUB, 5'd0, 5'd31, 5'd31, 1'b1);
    endtask

    // Build an arbitrary constant with dependent back-to-back ADDs.
    task automatic load_const(input logic [4:0] d, input logic [31:0] v);
        logic started;
        started = 1'b0;
        issue(OP_AND, 5'd0, 5'd0, d, 1'b1);
        for (int i = 31; i >= 0; i--) begin
            if (started) issue(OP_ADD, d, d, d, 1'b1);
            if (v[i]) begin
                issue(OP_ADD, d, 5'd31, d, 1'b1);
                started = 1'b1;
            end
        end
    endtask

    task automatic run_table(input string tag, input vec_t t [], input int n);
        for (int i = 0; i < n; i++) begin
            issue(t[i].op, t[i].a, t[i].b, t[i].d, t[i].we);
            #1;
            chk($sformatf("%s[%0d].result", tag, i), result, t[i].exp);
            chk($sformatf("%s[%0d].zero", tag, i), 32'(zero_flag), 32'(t[i].exp == 32'd0));
        end
    endtask

    vec_t t30 [];
    vec_t t31 [];
    vec_t t16 [];

    initial begin
        t30 = new[2];
        t30[0] = '{OP_SUB, 5'd1, 5'd2, 5'd3, 1'b1, 32'd2};
        t30[1] = '{OP_ADD, 5'd3, 5'd3, 5'd4, 1'b1, 32'd4};

        t31 = new[14];
        t31[0]  = '{OP_SLT,  5'd1, 5'd2, 5'd10, 1'b1, 32'h0000_0001};
        t31[1]  = '{OP_SLTU, 5'd1, 5'd2, 5'd10, 1'b1, 32'h0000_0000};
        t31[2]  = '{OP_SRA,  5'd1, 5'd2, 5'd10, 1'b1, 32'hC000_0000};
        t31[3]  = '{OP_SRL,  5'd1, 5'd2, 5'd10, 1'b1, 32'h4000_0000};
        t31[4]  = '{OP_ADD,  5'd1, 5'd1, 5'd10, 1'b1, 32'h0000_0000};
        t31[5]  = '{OP_SLL,  5'd1, 5'd2, 5'd10, 1'b1, 32'h0000_0000};
        t31[6]  = '{OP_XOR,  5'd1, 5'd2, 5'd10, 1'b1, 32'h8000_0001};
        t31[7]  = '{OP_OR,   5'd1, 5'd2, 5'd10, 1'b1, 32'h8000_0001};
        t31[8]  = '{OP_AND,  5'd1, 5'd2, 5'd10, 1'b1, 32'h0000_0000};
        t31[9]  = '{OP_NOR,  5'd1, 5'd2, 5'd10, 1'b1, 32'h7FFF_FFFE};
        t31[10] = '{OP_SUB,  5'd2, 5'd1, 5'd10, 1'b1, 32'h8000_0001};
        t31[11] = '{OP_SLT,  5'd2, 5'd1, 5'd10, 1'b1, 32'h0000_0000};
        t31[12] = '{4'hA,    5'd1, 5'd2, 5'd10, 1'b1, 32'h0000_0000};
        t31[13] = '{4'hF,    5'd1, 5'd2, 5'd10, 1'b1, 32'h0000_0000};

        // 16-bit instance: build 1,2,4,5,7 from nothing, then the SUB/ADD pair.
        t16 = new[8];
        t16[0] = '{OP_NOR, 5'd0, 5'd0, 5'd1, 1'b1, 32'h0000_FFFF};
        t16[1] = '{OP_SUB, 5'd0, 5'd1, 5'd1, 1'b1, 32'd1};
        t16[2] = '{OP_ADD, 5'd1, 5'd1, 5'd2, 1'b1, 32'd2};
        t16[3] = '{OP_ADD, 5'd2, 5'd2, 5'd3, 1'b1, 32'd4};
        t16[4] = '{OP_ADD, 5'd3, 5'd1, 5'd4, 1'b1, 32'd5};
        t16[5] = '{OP_ADD, 5'd4, 5'd2, 5'd5, 1'b1, 32'd7};
        t16[6] = '{OP_SUB, 5'd5, 5'd4, 5'd6, 1'b1, 32'd2};
        t16[7] = '{OP_ADD, 5'd6, 5'd6, 5'd7, 1'b1, 32'd4};

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; wr_en = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0; alu_ctrl = '0; dbg_addr = '0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_wr_en = 1'b0;
        s_rs1 = '0; s_rs2 = '0; s_rd = '0; s_alu = '0; s_dbg_addr = '0;

        // Reset for two edges without comparing pre-reset X.
        repeat (2) begin
            @(posedge clk);
            model_update();
            #1;
        end
        reset = 1'b1;
        #1;
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.in_ready",  32'(in_ready),  32'd1);
        chk("reset.result",    result,         32'd0);
        chk("reset.zero_flag", 32'(zero_flag), 32'd0);

        // ADD x0+x0 -> x5: result 0, zero flag set, x5 commits 0.
        issue(OP_ADD, 5'd0, 5'd0, 5'd5, 1'b1);
        #1;
        chk("first.out_valid", 32'(out_valid), 32'd1);
        chk("first.result",    result,         32'd0);
        chk("first.zero_flag", 32'(zero_flag), 32'd1);
        step();
        dbg_addr = 5'd5;
        #1;
        chk("first.dbg_x5", dbg_data, 32'd0);

        // x1=7, x2=5, then dependent SUB/ADD pair.
        make_one();
        load_const(5'd1, 32'd7);
        load_const(5'd2, 32'd5);
        run_table("fwd", t30, 2);
        step();
        dbg_addr = 5'd4;
        #1;
        chk("fwd.dbg_x4", dbg_data, 32'd4);

        // Write to x0 is visible on result but never committed or forwarded.
        issue(OP_ADD, 5'd1, 5'd0, 5'd0, 1'b1);
        #1;
        chk("x0w.result", result, 32'd7);
        issue(OP_ADD, 5'd0, 5'd0, 5'd6, 1'b1);
        #1;
        chk("x0w.read_zero", result, 32'd0);
        dbg_addr = 5'd0;
        step();
        chk("x0w.dbg_x0", dbg_data, 32'd0);

        // Backpressure for 3 cycles, then retire and accept together.
        issue(OP_ADD, 5'd1, 5'd1, 5'd8, 1'b1);
        out_ready = 1'b0;
        alu_ctrl = OP_ADD; rs1_addr = 5'd8; rs2_addr = 5'd1; rd_addr = 5'd9; wr_en = 1'b1;
        in_valid = 1'b1;
        dbg_addr = 5'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall.in_ready", 32'(in_ready), 32'd0);
            chk("stall.result",   result,        32'd14);
            chk("stall.dbg_x8",   dbg_data,      32'd0);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        #1;
        chk("stall.new_result", result,          32'd21);
        chk("stall.out_valid",  32'(out_valid),  32'd1);
        chk("stall.dbg_x8_cmt", dbg_data,        32'd14);
        step();

        // Signed/unsigned compare, shift and wrap boundaries.
        load_const(5'd1, 32'h8000_0000);
        load_const(5'd2, 32'd1);
        run_table("edge", t31, 14);
        step();

        // Reset wins over a pending retire with writeback.
        issue(OP_ADD, 5'd1, 5'd2, 5'd12, 1'b1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        dbg_addr = 5'd12;
        #1;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.dbg_x12",   dbg_data,       32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);

        // Randomized traffic from a few random seeds in x1..x4.
        make_one();
        for (int r = 1; r <= 4; r++) load_const(5'(r), $urandom);
        for (int c = 0; c < 400; c++) begin
            if (!held) begin
                in_valid = ($urandom_range(0, 9) < 7);
                alu_ctrl = 4'($urandom_range(0, 15));
                rs1_addr = 5'($urandom_range(0, 7));
                rs2_addr = 5'($urandom_range(0, 7));
                rd_addr  = 5'($urandom_range(0, 7));
                wr_en    = ($urandom_range(0, 9) < 8);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            dbg_addr  = 5'($urandom_range(0, 7));
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        for (int r = 0; r < 32; r++) begin
            dbg_addr = 5'(r);
            step();
        end

        // 16-bit / 8-register instance.
        for (int i = 0; i < 8; i++) begin
            s_alu = t16[i].op; s_rs1 = 3'(t16[i].a); s_rs2 = 3'(t16[i].b);
            s_rd = 3'(t16[i].d); s_wr_en = t16[i].we; s_in_valid = 1'b1;
            #3;
            chk($sformatf("x16[%0d].in_ready", i), 32'(s_in_ready), 32'd1);
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
            chk($sformatf("x16[%0d].result", i), 32'(s_result), t16[i].exp);
            chk($sformatf("x16[%0d].valid", i), 32'(s_out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        s_dbg_addr = 3'd7;
        #1;
        chk("x16.dbg_x7", 32'(s_dbg_data), 32'd4);
        s_dbg_addr = 3'd6;
        #1;
        chk("x16.dbg_x6", 32'(s_dbg_data), 32'd2);
        s_dbg_addr = 3'd0;
        #1;
        chk("x16.dbg_x0", 32'(s_dbg_data), 32'd0);
        chk("x16.out_valid", 32'(s_out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
